// File: rtl/video_timing_monitor_pkg.sv
// Shared definitions for the video timing monitor: lock FSM states and checksum width.
package video_timing_monitor_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   localparam int SUM_W = 16;

endpackage

// File: rtl/video_timing_monitor_sync_edge_detect.sv
// pix_en-qualified sync sampler: normalises polarity and emits registered
// assert/deassert pulses, one clk after the sample register.
module sync_edge_detect #(
   parameter logic SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pix_en,
   input  logic sync,
   output logic level,
   output logic rise,
   output logic fall
);

   logic cur;
   logic prev;
   logic smp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur   <= 1'b0;
         prev  <= 1'b0;
         smp   <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         smp <= pix_en;
         if (pix_en) begin
            cur  <= (sync == SYNC_POL);
            prev <= cur;
         end
         level <= cur;
         rise  <= smp & cur & ~prev;
         fall  <= smp & ~cur & prev;
      end
   end

endmodule

// File: rtl/video_timing_monitor.sv
// Receive-side hsync/vsync/rgb checker: measures line/frame timing, sums rgb
// per frame and tracks lock over consecutive consistent frames.
module video_timing_monitor
   import video_timing_monitor_pkg::*;
#(
   parameter int   CW       = 10,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [2:0]       rgb,
   output logic [CW-1:0]    line_len,
   output logic [CW-1:0]    hsync_width,
   output logic [CW-1:0]    frame_lines,
   output logic [SUM_W-1:0] frame_sum,
   output logic             frame_done,
   output logic             locked,
   output logic             sync_err
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic h_lvl, h_rise, h_fall;
   logic v_lvl, v_rise, vsync_fall_unused;

   sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hsync (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en),
      .sync   (hsync),
      .level  (h_lvl),
      .rise   (h_rise),
      .fall   (h_fall)
   );

   sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vsync (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en),
      .sync   (vsync),
      .level  (v_lvl),
      .rise   (v_rise),
      .fall   (vsync_fall_unused)
   );

   // rgb and the sample strobe follow the same two-stage path as the sync edges
   logic       pe_q1, pe_q2;
   logic [2:0] rgb_q1, rgb_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pe_q1  <= 1'b0;
         pe_q2  <= 1'b0;
         rgb_q1 <= '0;
         rgb_q2 <= '0;
      end else begin
         pe_q1 <= pix_en;
         pe_q2 <= pe_q1;
         if (pix_en) rgb_q1 <= rgb;
         rgb_q2 <= rgb_q1;
      end
   end

   lock_state_t      state;
   logic [CW-1:0]    hcnt, hw, vcnt;
   logic [SUM_W-1:0] acc;
   logic             line_bad;

   logic [CW-1:0] hlen, vcnt_inc, hcnt_next, vcnt_next;
   logic          timeout, len_chg, bad_now, active;

   always_comb begin
      hlen      = hcnt + CW'(1);
      vcnt_inc  = vcnt + CW'(h_rise);
      hcnt_next = h_rise ? '0 : hlen;
      vcnt_next = v_rise ? '0 : vcnt_inc;
      timeout   = (hcnt_next == CNT_MAX) || (vcnt_next == CNT_MAX);
      len_chg   = h_rise && (hlen != line_len);
      bad_now   = line_bad || len_chg;
      active    = !h_lvl && !v_lvl;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SEARCH;
         hcnt        <= '0;
         hw          <= '0;
         vcnt        <= '0;
         acc         <= '0;
         line_bad    <= 1'b0;
         line_len    <= '0;
         hsync_width <= '0;
         frame_lines <= '0;
         frame_sum   <= '0;
         frame_done  <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (pe_q2) begin
            if (timeout) begin
               hcnt     <= '0;
               hw       <= '0;
               vcnt     <= '0;
               acc      <= '0;
               line_bad <= 1'b0;
               if (state != SEARCH) sync_err <= 1'b1;
               state  <= SEARCH;
               locked <= 1'b0;
            end else begin
               if (h_rise) begin
                  line_len <= hlen;
                  hcnt     <= '0;
                  if (len_chg) begin
                     line_bad <= 1'b1;
                     if (state == LOCKED) begin
                        sync_err <= 1'b1;
                        state    <= CHECK;
                        locked   <= 1'b0;
                     end
                  end
               end else begin
                  hcnt <= hlen;
               end

               if (h_fall) begin
                  hsync_width <= hw;
                  hw          <= '0;
               end else if (h_lvl && hw != CNT_MAX) begin
                  hw <= hw + CW'(1);
               end

               if (active) acc <= acc + SUM_W'(rgb_q2);
               vcnt <= vcnt_inc;

               // decided on the state held before this sample, so a coincident
               // line-length error in LOCKED yields a single sync_err pulse
               if (v_rise) begin
                  vcnt     <= '0;
                  acc      <= '0;
                  line_bad <= 1'b0;
                  case (state)
                     SEARCH: state <= CHECK;
                     CHECK: begin
                        frame_done  <= 1'b1;
                        frame_lines <= vcnt_inc;
                        frame_sum   <= acc;
                        if (!bad_now && vcnt_inc == frame_lines) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end
                     LOCKED: begin
                        frame_done  <= 1'b1;
                        frame_lines <= vcnt_inc;
                        frame_sum   <= acc;
                        if (bad_now || vcnt_inc != frame_lines) begin
                           sync_err <= 1'b1;
                           state    <= CHECK;
                           locked   <= 1'b0;
                        end
                     end
                     default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench: a sample-level behavioural model queues expected frame and
// error events; a monitor pops them whenever the DUT pulses frame_done/sync_err.
module tb_video_timing_monitor;

   localparam int LIMIT = 1023;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic        hsync;
   logic        vsync;
   logic [2:0]  rgb;
   logic [9:0]  line_len;
   logic [9:0]  hsync_width;
   logic [9:0]  frame_lines;
   logic [15:0] frame_sum;
   logic        frame_done;
   logic        locked;
   logic        sync_err;

   video_timing_monitor #(.CW(10), .SYNC_POL(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .line_len    (line_len),
      .hsync_width (hsync_width),
      .frame_lines (frame_lines),
      .frame_sum   (frame_sum),
      .frame_done  (frame_done),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lines;
      int sum;
      int len;
      int hsw;
      int lck;
   } frame_ev_t;

   frame_ev_t exp_done[$];
   int        exp_err[$];
   int        checks = 0;
   int        passes = 0;
   int        done_seen = 0;
   int        err_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: the stream seen as lines and frames, phase 0=waiting
   // for first vsync, 1=checking, 2=locked.
   bit m_hp, m_vp;
   int m_hc, m_hw, m_vc, m_acc, m_bad, m_phase;
   int m_len, m_hsw, m_fl, m_fs;

   task automatic model_reset();
      m_hp = 0; m_vp = 0;
      m_hc = 0; m_hw = 0; m_vc = 0; m_acc = 0; m_bad = 0; m_phase = 0;
      m_len = 0; m_hsw = 0; m_fl = 0; m_fs = 0;
   endtask

   task automatic model_sample(input bit h, input bit v, input int c);
      bit hr, hf, vr, err, done, bad_now;
      int nl, nv, lines, ph0, prev;
      hr = h && !m_hp;
      hf = !h && m_hp;
      vr = v && !m_vp;
      m_hp = h;
      m_vp = v;
      err = 0;
      done = 0;
      ph0 = m_phase;
      nl = hr ? 0 : m_hc + 1;
      lines = m_vc + (hr ? 1 : 0);
      nv = vr ? 0 : lines;
      if (nl == LIMIT || nv == LIMIT) begin
         err = (m_phase != 0);
         m_phase = 0;
         m_hc = 0; m_hw = 0; m_vc = 0; m_acc = 0; m_bad = 0;
      end else begin
         bad_now = (m_bad != 0);
         if (hr) begin
            if (m_hc + 1 != m_len) begin
               bad_now = 1;
               m_bad = 1;
               if (m_phase == 2) begin
                  err = 1;
                  m_phase = 1;
               end
            end
            m_len = m_hc + 1;
         end
         m_hc = nl;
         if (hf) begin
            m_hsw = m_hw;
            m_hw = 0;
         end else if (h && m_hw < LIMIT) m_hw++;
         if (!h && !v) m_acc = (m_acc + c) % 65536;
         m_vc = nv;
         if (vr) begin
            if (ph0 == 0) m_phase = 1;
            else begin
               done = 1;
               prev = m_fl;
               m_fl = lines;
               m_fs = m_acc;
               if (ph0 == 1) begin
                  if (!bad_now && lines == prev) m_phase = 2;
               end else if (bad_now || lines != prev) begin
                  err = 1;
                  m_phase = 1;
               end
            end
            m_acc = 0;
            m_bad = 0;
         end
      end
      if (done) exp_done.push_back('{m_fl, m_fs, m_len, m_hsw, (m_phase == 2) ? 1 : 0});
      if (err) exp_err.push_back((m_phase == 2) ? 1 : 0);
   endtask

   // Called at posedge+1; leaves the bench at posedge+1.
   task automatic send_sample(input bit h, input bit v, input int c, input int gap);
      hsync = h;
      vsync = v;
      rgb = 3'(c);
      pix_en = 1'b1;
      model_sample(h, v, c);
      @(posedge clk); #1;
      pix_en = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   // mode 0: rgb=7; mode 1: one active pixel of 5; mode 2: random rgb
   task automatic send_frame(input int nlines, input int bad_line, input int mode,
                             input int pause_line, input bit rand_gap);
      int len, c, gap;
      for (int ln = 0; ln < nlines; ln++) begin
         len = (ln == bad_line) ? 21 : 20;
         for (int s = 0; s < len; s++) begin
            case (mode)
               0:       c = 7;
               1:       c = (ln == 5 && s == 10) ? 5 : 0;
               default: c = $urandom_range(0, 7);
            endcase
            gap = rand_gap ? $urandom_range(1, 3) : 1;
            if (ln == pause_line && s == 8) begin
               repeat (50) @(posedge clk);
               #1;
            end
            send_sample(s < 3, ln < 2, c, gap);
         end
      end
   endtask

   task automatic drain_check(input string tag);
      repeat (5) @(posedge clk);
      #1;
      check({tag, " frame events left"}, exp_done.size(), 0);
      check({tag, " error events left"}, exp_err.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " line_len"}, int'(line_len), 0);
      check({tag, " hsync_width"}, int'(hsync_width), 0);
      check({tag, " frame_lines"}, int'(frame_lines), 0);
      check({tag, " frame_sum"}, int'(frame_sum), 0);
      check({tag, " frame_done"}, int'(frame_done), 0);
      check({tag, " locked"}, int'(locked), 0);
      check({tag, " sync_err"}, int'(sync_err), 0);
   endtask

   frame_ev_t ev;
   int        e_lck;

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_done) begin
            done_seen++;
            check("frame_done expected", (exp_done.size() > 0) ? 1 : 0, 1);
            if (exp_done.size() > 0) begin
               ev = exp_done.pop_front();
               check("frame_lines", int'(frame_lines), ev.lines);
               check("frame_sum", int'(frame_sum), ev.sum);
               check("line_len", int'(line_len), ev.len);
               check("hsync_width", int'(hsync_width), ev.hsw);
               check("locked at frame_done", int'(locked), ev.lck);
            end
         end
         if (sync_err) begin
            err_seen++;
            check("sync_err expected", (exp_err.size() > 0) ? 1 : 0, 1);
            if (exp_err.size() > 0) begin
               e_lck = exp_err.pop_front();
               check("locked at sync_err", int'(locked), e_lck);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   int errs0, done0;

   initial begin
      reset = 1'b1;
      pix_en = 1'b0;
      hsync = 1'b0;
      vsync = 1'b0;
      rgb = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // nominal stream: lock on the 3rd vsync edge
      repeat (6) send_frame(10, -1, 0, -1, 1'b0);
      drain_check("nominal");
      check("nominal locked", int'(locked), 1);
      check("nominal line_len", int'(line_len), 20);
      check("nominal hsync_width", int'(hsync_width), 3);
      check("nominal frame_lines", int'(frame_lines), 10);
      check("nominal frame_sum", int'(frame_sum), 952);

      // one long line breaks lock immediately; clean frames relock
      errs0 = err_seen;
      send_frame(10, 4, 0, -1, 1'b0);
      drain_check("long line");
      check("long line locked", int'(locked), 0);
      check("long line sync_err count", err_seen - errs0, 1);
      repeat (3) send_frame(10, -1, 0, -1, 1'b0);
      drain_check("relock");
      check("relock locked", int'(locked), 1);

      // single active pixel per frame
      repeat (3) send_frame(10, -1, 1, -1, 1'b0);
      drain_check("single pixel");
      check("single pixel frame_sum", int'(frame_sum), 5);

      // random colours, random pix_en spacing, occasional long line
      repeat (5) send_frame(10, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : -1,
                            2, -1, 1'b1);
      repeat (3) send_frame(10, -1, 2, -1, 1'b1);
      drain_check("random");
      check("random relock", int'(locked), 1);

      // pix_en stalled 50 clks mid-line
      errs0 = err_seen;
      send_frame(10, -1, 0, 3, 1'b0);
      send_frame(10, -1, 0, -1, 1'b0);
      drain_check("stall");
      check("stall locked", int'(locked), 1);
      check("stall sync_err count", err_seen - errs0, 0);

      // hsync missing long enough to time out
      errs0 = err_seen;
      for (int i = 0; i < 1100; i++) send_sample(1'b0, 1'b0, 0, 1);
      drain_check("timeout");
      check("timeout locked", int'(locked), 0);
      check("timeout sync_err count", err_seen - errs0, 1);
      repeat (3) send_frame(10, -1, 0, -1, 1'b0);
      drain_check("after timeout");
      check("after timeout locked", int'(locked), 1);

      // reset mid-line while locked
      send_frame(4, -1, 0, -1, 1'b0);
      send_sample(1'b1, 1'b0, 7, 1);
      send_sample(1'b0, 1'b0, 7, 1);
      drain_check("pre reset");
      reset = 1'b1;
      #1;
      check_zero("mid reset");
      exp_done.delete();
      exp_err.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      done0 = done_seen;
      send_frame(10, -1, 0, -1, 1'b0);
      drain_check("post reset 1");
      check("frame_done after 1st vsync", done_seen - done0, 0);
      send_frame(10, -1, 0, -1, 1'b0);
      drain_check("post reset 2");
      check("frame_done after 2nd vsync", done_seen - done0, 1);
      send_frame(10, -1, 0, -1, 1'b0);
      drain_check("post reset 3");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
